sb_arbiter: RTL
===============

# sb_arbiter

Two-master arbiter for the LED panel slow bus. It lets the GPMC host bridge (master 0) and a second on-chip master (master 1, e.g. a local sequencer or debug port) share the single-strobe slow bus (`sb_*`) that feeds the panel register targets. Each master gets a one-deep request holding register. Grants are round-robin, one transaction at a time, and read data returns to the requesting master after a fixed slave read latency.

## Interface
- `RD_LAT`, default 1: cycles from `sb_rd` high to `sb_rd_data` valid at the slave; legal range 1..15.
- `clk` in 1: system clock.
- `rst` in 1: synchronous, active-high reset.
- `m0_addr` in [16:1]: master 0 word address, sampled with strobe.
- `m0_wr` in 1: master 0 write strobe, one-cycle pulse.
- `m0_wr_data` in 16: master 0 write data, sampled with `m0_wr`.
- `m0_rd` in 1: master 0 read strobe, one-cycle pulse.
- `m0_rd_data` out 16: master 0 read result; held until the next master 0 read completes.
- `m0_rd_valid` out 1: one-cycle pulse when `m0_rd_data` is updated.
- `m0_busy` out 1: request pending or in flight for master 0.
- `m0_err` out 1: sticky; set when a strobe arrives while `m0_busy`=1.
- `m1_*`: identical set of ports for master 1.
- `sb_addr` out [16:1]: slow bus address.
- `sb_wr` out 1: slow bus write strobe.
- `sb_wr_data` out 16: slow bus write data.
- `sb_rd` out 1: slow bus read strobe.
- `sb_rd_data` in 16: slow bus read data.

## Operation
- Reset values: all `sb_*` outputs 0; `m*_rd_data` 0; `m*_rd_valid`, `m*_busy`, `m*_err` 0; FSM IDLE; last-grant = master 1, so master 0 wins the first tie.
- Capture: a strobe is accepted only in a cycle where `m*_busy`=0. It loads the holding register with addr, data and type, and sets pending.
  - `wr` and `rd` high in the same cycle: the write is accepted and the read is discarded. `err` is not set.
  - Strobe while busy: dropped, `m*_err`←1. The in-progress request is unaffected.
- `m*_busy` = pending, or that master owns the in-flight transaction.
- FSM states: IDLE, XFER, RD_WAIT.
  - IDLE: if any pending, grant it. If both are pending, grant the master not granted last. On the grant edge, load `sb_addr`/`sb_wr_data` from the holding register, assert `sb_wr` or `sb_rd`, clear pending, record owner and last-grant, go to XFER.
  - XFER: strobe is high for exactly this cycle. A write returns to IDLE. A read loads the latency counter with RD_LAT-1 and goes to RD_WAIT; when RD_LAT=1 the counter is already 0 on entry.
  - RD_WAIT: sample `sb_rd_data` in the cycle the counter is 0 (RD_LAT cycles after the `sb_rd` cycle). Load it into the owner's `rd_data`, pulse the owner's `rd_valid` the next cycle, return to IDLE. Otherwise decrement the counter.
- `sb_addr` and `sb_wr_data` hold their last value between transactions. `sb_wr_data` is loaded only on write grants.
- Reset mid-transaction: everything returns to reset values, the in-flight read is discarded, no `rd_valid` pulse.
- `m*_err` clears only on `rst`.

## Timing
- Write, master idle, bus idle:
  - strobe in cycle N
  - `busy` high from N+1
  - `sb_wr` high in N+2
  - `busy` low in N+3
- Read:
  - strobe in cycle N
  - `sb_rd` in N+2
  - `sb_rd_data` sampled in N+2+RD_LAT
  - `rd_valid` and new `rd_data` in N+3+RD_LAT; `busy` low in the same cycle
- A master may re-strobe in the cycle its `busy` goes low.
- Minimum spacing between slow bus strobes: 2 cycles for writes, RD_LAT+2 for reads.
- Worst-case wait for a pending request: one transaction of the other master.

## Test plan
- Reset, then `m0_wr` addr 0x0010 data 0xA5A5 at cycle N → `sb_wr`=1 only in N+2 with `sb_addr`=0x0010, `sb_wr_data`=0xA5A5; `m0_busy` high N+1..N+2.
- RD_LAT=3, `m1_rd` addr 0x0004, slave returns 0x1234 at `sb_rd`+3 → `m1_rd_valid` one pulse at N+6, `m1_rd_data`=0x1234, `m0_rd_valid` stays 0.
- `m0_wr` and `m1_wr` in the same cycle, repeated 4 times → grants alternate m0, m1, m0, m1…; first grant m0 after reset.
- `m0_wr` then `m0_rd` while `m0_busy`=1 → read dropped, `m0_err`=1 and stays 1; only one `sb_wr` pulse, no `sb_rd`.
- `m0_wr` and `m0_rd` in the same cycle → one write issued, no read, `m0_err`=0.
- Assert `rst` during RD_WAIT → no `rd_valid`, all outputs at reset values next cycle, next `m0_rd` completes normally.

Source files
------------

// File: rtl/sb_arbiter.sv
// Two-master round-robin arbiter for the LED panel slow bus.
// Each master has a one-deep holding register; read data is routed back to the owner after RD_LAT cycles.
module sb_arbiter #(
    parameter int RD_LAT = 1
) (
    input  logic        clk,
    input  logic        rst,

    input  logic [16:1] m0_addr,
    input  logic        m0_wr,
    input  logic [15:0] m0_wr_data,
    input  logic        m0_rd,
    output logic [15:0] m0_rd_data,
    output logic        m0_rd_valid,
    output logic        m0_busy,
    output logic        m0_err,

    input  logic [16:1] m1_addr,
    input  logic        m1_wr,
    input  logic [15:0] m1_wr_data,
    input  logic        m1_rd,
    output logic [15:0] m1_rd_data,
    output logic        m1_rd_valid,
    output logic        m1_busy,
    output logic        m1_err,

    output logic [16:1] sb_addr,
    output logic        sb_wr,
    output logic [15:0] sb_wr_data,
    output logic        sb_rd,
    input  logic [15:0] sb_rd_data
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] XFER    = 2'd1;
    localparam logic [1:0] RD_WAIT = 2'd2;

    logic [1:0]  state;
    logic [3:0]  lat_cnt;
    logic        owner;
    logic        last_grant;

    logic [1:0]  pend;
    logic [1:0]  hold_wr;
    logic [16:1] hold_addr [2];
    logic [15:0] hold_data [2];

    logic [1:0]  err;
    logic [1:0]  rd_valid;
    logic [15:0] rd_data [2];

    logic [1:0]  busy;
    logic [1:0]  in_wr;
    logic [1:0]  in_rd;
    logic [16:1] in_addr [2];
    logic [15:0] in_data [2];

    logic        grant_valid;
    logic        grant_sel;

    assign in_wr      = {m1_wr, m0_wr};
    assign in_rd      = {m1_rd, m0_rd};
    assign in_addr[0] = m0_addr;
    assign in_addr[1] = m1_addr;
    assign in_data[0] = m0_wr_data;
    assign in_data[1] = m1_wr_data;

    // A master stays busy from capture until its own transaction leaves the bus.
    assign busy[0] = pend[0] | ((state != IDLE) & ~owner);
    assign busy[1] = pend[1] | ((state != IDLE) & owner);

    // On a tie the master that did not win last time goes first.
    assign grant_valid = (state == IDLE) & (|pend);
    assign grant_sel   = (&pend) ? ~last_grant : pend[1];

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            lat_cnt    <= '0;
            owner      <= 1'b0;
            last_grant <= 1'b1;
            pend       <= '0;
            hold_wr    <= '0;
            err        <= '0;
            rd_valid   <= '0;
            sb_addr    <= '0;
            sb_wr      <= 1'b0;
            sb_wr_data <= '0;
            sb_rd      <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                hold_addr[i] <= '0;
                hold_data[i] <= '0;
                rd_data[i]   <= '0;
            end
        end else begin
            rd_valid <= '0;

            // A write wins over a simultaneous read; strobes while busy are dropped and flagged.
            for (int i = 0; i < 2; i++) begin
                if (in_wr[i] || in_rd[i]) begin
                    if (!busy[i]) begin
                        pend[i]      <= 1'b1;
                        hold_wr[i]   <= in_wr[i];
                        hold_addr[i] <= in_addr[i];
                        hold_data[i] <= in_data[i];
                    end else begin
                        err[i] <= 1'b1;
                    end
                end
            end

            case (state)
                IDLE: begin
                    if (grant_valid) begin
                        pend[grant_sel] <= 1'b0;
                        owner           <= grant_sel;
                        last_grant      <= grant_sel;
                        sb_addr         <= hold_addr[grant_sel];
                        if (hold_wr[grant_sel]) begin
                            sb_wr      <= 1'b1;
                            sb_wr_data <= hold_data[grant_sel];
                        end else begin
                            sb_rd <= 1'b1;
                        end
                        state <= XFER;
                    end
                end
                XFER: begin
                    sb_wr <= 1'b0;
                    sb_rd <= 1'b0;
                    if (sb_rd) begin
                        lat_cnt <= 4'(RD_LAT - 1);
                        state   <= RD_WAIT;
                    end else begin
                        state <= IDLE;
                    end
                end
                RD_WAIT: begin
                    if (lat_cnt == 4'd0) begin
                        rd_data[owner]  <= sb_rd_data;
                        rd_valid[owner] <= 1'b1;
                        state           <= IDLE;
                    end else begin
                        lat_cnt <= lat_cnt - 4'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign m0_rd_data  = rd_data[0];
    assign m1_rd_data  = rd_data[1];
    assign m0_rd_valid = rd_valid[0];
    assign m1_rd_valid = rd_valid[1];
    assign m0_busy     = busy[0];
    assign m1_busy     = busy[1];
    assign m0_err      = err[0];
    assign m1_err      = err[1];

endmodule
